// File: rtl/usb_utm_tx_if.sv
// usb_utm_tx_if: UTMI transmit-side bundle between the protocol
// engine (master) and the FS transmit macrocell (slave).
interface usb_utm_tx_if;
  logic [1:0] op_mode;
  logic [7:0] data_in;
  logic       tx_valid;
  logic       tx_ready;
  logic       dp_tx;
  logic       dn_tx;
  logic       tx_oe;

  modport master (
    output op_mode,
    output data_in,
    output tx_valid,
    input  tx_ready,
    input  dp_tx,
    input  dn_tx,
    input  tx_oe
  );

  modport slave (
    input  op_mode,
    input  data_in,
    input  tx_valid,
    output tx_ready,
    output dp_tx,
    output dn_tx,
    output tx_oe
  );
endinterface

// File: rtl/usb_utm_tx.sv
// usb_utm_tx: full-speed USB transmit path, UTM side of UTMI.
// Adds SYNC, bit-stuffs, NRZI-encodes and appends EOP on D+/D-.
module usb_utm_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  usb_utm_tx_if.slave bus
);
  localparam int CW = $clog2(CLK_DIV);

  typedef enum logic [2:0] {
    IDLE, SYNC, DATA, EOP_SE0, EOP_J
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    sr;
  logic [2:0]    rem;
  logic [2:0]    ones;
  logic          raw;
  logic          dp;
  logic          dn;
  logic          oe;
  logic          rdy;

  logic strobe;
  logic stuff;
  logic byte_end;
  logic out_bit;
  logic nxt_dp;
  logic abort;

  always_comb begin
    strobe   = cnt == CW'(CLK_DIV - 1);
    stuff    = !raw && ones == 3'd6;
    byte_end = rem == 3'd0;
    out_bit  = byte_end ? bus.data_in[0] : sr[0];
    abort    = bus.op_mode[0];
    // stuff bit is a forced 0, raw drives the bit level as-is
    if (stuff)
      nxt_dp = ~dp;
    else if (raw)
      nxt_dp = out_bit;
    else
      nxt_dp = out_bit ? dp : ~dp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
      rem   <= '0;
      ones  <= '0;
      raw   <= 1'b0;
      dp    <= 1'b1;
      dn    <= 1'b0;
      oe    <= 1'b0;
      rdy   <= 1'b0;
    end else begin
      rdy <= 1'b0;
      cnt <= (strobe || state == IDLE) ? '0 : cnt + 1'b1;
      if (state != IDLE && abort) begin
        state <= IDLE;
        dp    <= 1'b1;
        dn    <= 1'b0;
        oe    <= 1'b0;
      end else begin
        unique case (state)
          IDLE: if (bus.tx_valid && !abort) begin
            oe   <= 1'b1;
            rem  <= 3'd7;
            ones <= '0;
            raw  <= bus.op_mode[1];
            if (bus.op_mode[1]) begin
              state <= DATA;
              sr    <= bus.data_in >> 1;
              rdy   <= 1'b1;
              dp    <= bus.data_in[0];
              dn    <= ~bus.data_in[0];
            end else begin
              // SYNC 0x80: first bit 0 goes out now as K
              state <= SYNC;
              sr    <= 8'h40;
              dp    <= 1'b0;
              dn    <= 1'b1;
            end
          end
          SYNC, DATA: if (strobe) begin
            if (stuff) begin
              ones <= '0;
              dp   <= nxt_dp;
              dn   <= ~nxt_dp;
            end else if (!byte_end || bus.tx_valid) begin
              dp   <= nxt_dp;
              dn   <= ~nxt_dp;
              ones <= out_bit ? ones + 3'd1 : '0;
              if (byte_end) begin
                sr    <= bus.data_in >> 1;
                rem   <= 3'd7;
                rdy   <= 1'b1;
                state <= DATA;
              end else begin
                sr  <= sr >> 1;
                rem <= rem - 3'd1;
              end
            end else if (raw) begin
              state <= IDLE;
              dp    <= 1'b1;
              dn    <= 1'b0;
              oe    <= 1'b0;
            end else begin
              state <= EOP_SE0;
              rem   <= 3'd1;
              dp    <= 1'b0;
              dn    <= 1'b0;
            end
          end
          EOP_SE0: if (strobe) begin
            if (rem != 3'd0) begin
              rem <= rem - 3'd1;
            end else begin
              state <= EOP_J;
              dp    <= 1'b1;
              dn    <= 1'b0;
            end
          end
          EOP_J: if (strobe) begin
            state <= IDLE;
            oe    <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.tx_ready = rdy;
  assign bus.dp_tx    = dp;
  assign bus.dn_tx    = dn;
  assign bus.tx_oe    = oe;
endmodule

// File: tb/tb_usb_utm_tx.sv
// tb_usb_utm_tx: directed checks of the FS transmit path
// against hand-derived line sequences and tx_ready timing.
module tb_usb_utm_tx;
  logic clk = 1'b0;
  logic rst;
  int   pass_cnt = 0;
  int   tot_cnt  = 0;

  usb_utm_tx_if u ();

  usb_utm_tx #(.CLK_DIV(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(u.slave)
  );

  always #5 clk = ~clk;

  logic       s_dp [0:199];
  logic       s_dn [0:199];
  logic       s_oe [0:199];
  logic [7:0] pkt  [0:3];
  int         rdy_at [0:7];
  int         rdy_n;

  // Drive one packet from pkt[] and record the line; call at a negedge.
  task automatic run_pkt(input int nb, input int ncyc);
    rdy_n = 0;
    u.data_in  = pkt[0];
    u.tx_valid = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      s_dp[i] = u.dp_tx;
      s_dn[i] = u.dn_tx;
      s_oe[i] = u.tx_oe;
      if (u.tx_ready === 1'b1) begin
        if (rdy_n < 8) rdy_at[rdy_n] = i;
        rdy_n++;
        if (rdy_n >= nb) u.tx_valid = 1'b0;
        else u.data_in = pkt[rdy_n];
      end
    end
  endtask

  // Index of first sample off the expected per-bit-time symbols, or -1.
  function automatic int line_err(input string exp);
    logic [1:0] w;
    byte        c;
    for (int i = 0; i < 4 * exp.len(); i++) begin
      c = exp[i / 4];
      case (c)
        "J":     w = 2'b10;
        "K":     w = 2'b01;
        default: w = 2'b00;
      endcase
      if ({s_dp[i], s_dn[i]} !== w || s_oe[i] !== 1'b1) return i;
    end
    return -1;
  endfunction

  // Index of first sample in [a,b) not idle (J, undriven), or -1.
  function automatic int idle_err(input int a, input int b);
    for (int i = a; i < b; i++)
      if (s_dp[i] !== 1'b1 || s_dn[i] !== 1'b0 || s_oe[i] !== 1'b0)
        return i;
    return -1;
  endfunction

  task automatic test_reset;
    int e;
    repeat (3) @(negedge clk);
    tot_cnt++;
    if ({u.tx_oe, u.dp_tx, u.dn_tx, u.tx_ready} !== 4'b0100)
      $display("FAIL reset_out: got %b want 0100",
               {u.tx_oe, u.dp_tx, u.dn_tx, u.tx_ready});
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    tot_cnt++;
    if ({u.tx_oe, u.dp_tx, u.dn_tx, u.tx_ready} !== 4'b0100)
      $display("FAIL idle_out: got %b want 0100",
               {u.tx_oe, u.dp_tx, u.dn_tx, u.tx_ready});
    else pass_cnt++;
    e = 0;
  endtask

  task automatic test_byte00;
    int e;
    pkt[0] = 8'h00;
    run_pkt(1, 84);
    e = line_err("KJKJKJKKJKJKJKJK00J");
    tot_cnt++;
    if (e !== -1) $display("FAIL b00_line: bad sample %0d want -1", e);
    else pass_cnt++;
    e = idle_err(76, 84);
    tot_cnt++;
    if (e !== -1) $display("FAIL b00_idle: bad sample %0d want -1", e);
    else pass_cnt++;
    tot_cnt++;
    if (rdy_n !== 1 || rdy_at[0] !== 32)
      $display("FAIL b00_ready: got n=%0d at %0d want n=1 at 32",
               rdy_n, rdy_at[0]);
    else pass_cnt++;
  endtask

  task automatic test_byteff;
    int e;
    pkt[0] = 8'hFF;
    run_pkt(1, 88);
    e = line_err("KJKJKJKKKKKKKJJJJ00J");
    tot_cnt++;
    if (e !== -1) $display("FAIL bff_line: bad sample %0d want -1", e);
    else pass_cnt++;
    e = idle_err(80, 88);
    tot_cnt++;
    if (e !== -1) $display("FAIL bff_idle: bad sample %0d want -1", e);
    else pass_cnt++;
    tot_cnt++;
    if (rdy_n !== 1 || rdy_at[0] !== 32)
      $display("FAIL bff_ready: got n=%0d at %0d want n=1 at 32",
               rdy_n, rdy_at[0]);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int e;
    pkt[0] = 8'hA5;
    pkt[1] = 8'h3C;
    pkt[2] = 8'h5A;
    run_pkt(3, 150);
    e = line_err({"KJKJKJKK", "KJJKJJKK", "JKKKKKJK", "JJKKKJJK", "00J"});
    tot_cnt++;
    if (e !== -1) $display("FAIL b2b_line: bad sample %0d want -1", e);
    else pass_cnt++;
    e = idle_err(140, 150);
    tot_cnt++;
    if (e !== -1) $display("FAIL b2b_idle: bad sample %0d want -1", e);
    else pass_cnt++;
    tot_cnt++;
    if (rdy_n !== 3 || rdy_at[0] !== 32 || rdy_at[1] !== 64 ||
        rdy_at[2] !== 96)
      $display("FAIL b2b_ready: got n=%0d at %0d,%0d,%0d want 3 at 32,64,96",
               rdy_n, rdy_at[0], rdy_at[1], rdy_at[2]);
    else pass_cnt++;
  endtask

  task automatic test_nondrive;
    int e;
    u.op_mode = 2'b01;
    pkt[0] = 8'h00;
    run_pkt(99, 100);
    e = idle_err(0, 100);
    tot_cnt++;
    if (e !== -1) $display("FAIL nd_line: bad sample %0d want -1", e);
    else pass_cnt++;
    tot_cnt++;
    if (rdy_n !== 0) $display("FAIL nd_ready: got %0d want 0", rdy_n);
    else pass_cnt++;
    u.tx_valid = 1'b0;
    u.op_mode  = 2'b00;
    @(negedge clk);
    run_pkt(1, 40);
    u.op_mode = 2'b01;
    @(negedge clk);
    tot_cnt++;
    if ({u.tx_oe, u.dp_tx, u.dn_tx} !== 3'b010)
      $display("FAIL abort_out: got %b want 010",
               {u.tx_oe, u.dp_tx, u.dn_tx});
    else pass_cnt++;
    u.op_mode = 2'b00;
    repeat (12) @(negedge clk);
    tot_cnt++;
    if ({u.tx_oe, u.dp_tx, u.dn_tx} !== 3'b010)
      $display("FAIL abort_noeop: got %b want 010",
               {u.tx_oe, u.dp_tx, u.dn_tx});
    else pass_cnt++;
  endtask

  task automatic test_raw;
    int e;
    u.op_mode = 2'b10;
    for (int i = 0; i < 4; i++) pkt[i] = 8'h00;
    run_pkt(4, 136);
    e = line_err("KKKKKKKKKKKKKKKKKKKKKKKKKKKKKKKK");
    tot_cnt++;
    if (e !== -1) $display("FAIL raw_line: bad sample %0d want -1", e);
    else pass_cnt++;
    e = idle_err(128, 136);
    tot_cnt++;
    if (e !== -1) $display("FAIL raw_idle: bad sample %0d want -1", e);
    else pass_cnt++;
    tot_cnt++;
    if (rdy_n !== 4 || rdy_at[0] !== 0 || rdy_at[1] !== 32 ||
        rdy_at[2] !== 64 || rdy_at[3] !== 96)
      $display("FAIL raw_ready: got n=%0d at %0d,%0d,%0d,%0d want 4 at 0,32,64,96",
               rdy_n, rdy_at[0], rdy_at[1], rdy_at[2], rdy_at[3]);
    else pass_cnt++;
    u.op_mode = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_rst_mid;
    int e;
    pkt[0] = 8'hFF;
    run_pkt(1, 50);
    rst = 1'b1;
    @(negedge clk);
    tot_cnt++;
    if ({u.tx_oe, u.dp_tx, u.dn_tx, u.tx_ready} !== 4'b0100)
      $display("FAIL rst_mid_out: got %b want 0100",
               {u.tx_oe, u.dp_tx, u.dn_tx, u.tx_ready});
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    run_pkt(1, 88);
    e = line_err("KJKJKJKKKKKKKJJJJ00J");
    tot_cnt++;
    if (e !== -1) $display("FAIL rst_resync: bad sample %0d want -1", e);
    else pass_cnt++;
    tot_cnt++;
    if (rdy_n !== 1 || rdy_at[0] !== 32)
      $display("FAIL rst_ready: got n=%0d at %0d want n=1 at 32",
               rdy_n, rdy_at[0]);
    else pass_cnt++;
  endtask

  initial begin
    rst        = 1'b1;
    u.op_mode  = 2'b00;
    u.data_in  = 8'h00;
    u.tx_valid = 1'b0;
    test_reset;
    test_byte00;
    test_byteff;
    test_back_to_back;
    test_nondrive;
    test_raw;
    test_rst_mid;
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
